// File: rtl/serial_mem_pkg.sv
// serial_mem_pkg
//   Shared definitions for the byte-serial memory responder:
//   - command byte encodings recognised at the start of a frame
//   - default acknowledge byte returned after a write
//   - FSM state encoding
package serial_mem_pkg;

  localparam logic [7:0] CMD_READ         = 8'h01;
  localparam logic [7:0] CMD_WRITE        = 8'h02;
  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA_HI,
    DATA_LO,
    RD_FETCH,
    WR_COMMIT,
    TX_HI,
    TX_LO,
    TX_ACK
  } smr_state_t;

endpackage

// File: rtl/word_ram.sv
// word_ram
//   16-bit wide single-port synchronous RAM, 2**ADDR_W words.
//   Read is registered (data appears the cycle after the address);
//   a write in the same cycle returns the old contents on rdata.
//   Contents are never reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   addr   in   word address [ADDR_W-1:0]
//   wdata  in   write data [15:0]
//   rdata  out  registered read data [15:0]
module word_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/serial_mem_responder.sv
// serial_mem_responder
//   Byte-serial memory endpoint for the CPU's 8-bit serial bus. Accepts
//   frames {cmd, addr_hi, addr_lo [, data_hi, data_lo]}, performs 16-bit
//   word reads/writes on an internal RAM and returns the response bytes
//   (read word high-then-low, or ACK_BYTE after a write) over a
//   valid/ready handshake.
// Ports:
//   clk       in   clock, all state on rising edge
//   rst_n     in   asynchronous active-low reset
//   rx_byte   in   [7:0] byte from the CPU
//   rx_valid  in   rx_byte valid strobe
//   tx_byte   out  [7:0] response byte
//   tx_valid  out  response byte valid, held until accepted
//   tx_ready  in   CPU accepts tx_byte when tx_valid && tx_ready
//   busy      out  high whenever a frame is in progress
//   err       out  one-cycle pulse after a bad command or a byte that
//                  arrives while a frame is being serviced
module serial_mem_responder
  import serial_mem_pkg::*;
#(
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] ACK_BYTE = DEFAULT_ACK_BYTE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       err
);

  smr_state_t        state_reg, state_next;
  logic              is_write_reg, is_write_next;
  logic [15:0]       addr_reg, addr_next;
  logic [15:0]       data_reg, data_next;
  logic [7:0]        tx_byte_reg, tx_byte_next;
  logic              err_reg, err_next;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_rdata;
  logic              tx_fire;

  word_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data_reg),
    .rdata (ram_rdata)
  );

  assign tx_valid = (state_reg == TX_HI) || (state_reg == TX_LO) || (state_reg == TX_ACK);
  assign busy     = (state_reg != IDLE);
  assign tx_byte  = tx_byte_reg;
  assign err      = err_reg;
  assign tx_fire  = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      is_write_reg <= 1'b0;
      addr_reg     <= 16'h0000;
      data_reg     <= 16'h0000;
      tx_byte_reg  <= 8'h00;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      is_write_reg <= is_write_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      tx_byte_reg  <= tx_byte_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    is_write_next = is_write_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    tx_byte_next  = tx_byte_reg;
    err_next      = 1'b0;
    ram_we        = 1'b0;
    // Upper address bits beyond ADDR_W are dropped: addresses wrap.
    ram_addr      = ADDR_W'(addr_reg);

    unique case (state_reg)
      IDLE: begin
        if (rx_valid) begin
          if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
            is_write_next = (rx_byte == CMD_WRITE);
            state_next    = ADDR_HI;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      ADDR_HI: begin
        if (rx_valid) begin
          addr_next[15:8] = rx_byte;
          state_next      = ADDR_LO;
        end
      end

      ADDR_LO: begin
        // Present the full address straight from the incoming byte so the
        // registered RAM read completes by RD_FETCH; this is what lets the
        // high byte be loaded into tx_byte one cycle later.
        ram_addr = ADDR_W'({addr_reg[15:8], rx_byte});
        if (rx_valid) begin
          addr_next[7:0] = rx_byte;
          state_next     = is_write_reg ? DATA_HI : RD_FETCH;
        end
      end

      DATA_HI: begin
        if (rx_valid) begin
          data_next[15:8] = rx_byte;
          state_next      = DATA_LO;
        end
      end

      DATA_LO: begin
        if (rx_valid) begin
          data_next[7:0] = rx_byte;
          state_next     = WR_COMMIT;
        end
      end

      RD_FETCH: begin
        err_next     = rx_valid;
        data_next    = ram_rdata;
        tx_byte_next = ram_rdata[15:8];
        state_next   = TX_HI;
      end

      WR_COMMIT: begin
        err_next     = rx_valid;
        ram_we       = 1'b1;
        tx_byte_next = ACK_BYTE;
        state_next   = TX_ACK;
      end

      TX_HI: begin
        err_next = rx_valid;
        if (tx_fire) begin
          tx_byte_next = data_reg[7:0];
          state_next   = TX_LO;
        end
      end

      TX_LO, TX_ACK: begin
        err_next = rx_valid;
        if (tx_fire) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_mem_responder.sv
// Testbench for serial_mem_responder. Expected response bytes come from a
// reference memory model and are queued when a frame is issued, then popped
// and compared when the responder presents them.
module tb_serial_mem_responder;
  import serial_mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       err;

  int total = 0;
  int bad = 0;

  logic [7:0]  exp_q [$];
  logic [15:0] model_mem [256];
  logic [7:0]  exp;

  always #5 clk = ~clk;

  serial_mem_responder #(
    .ADDR_W   (8),
    .ACK_BYTE (8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .err      (err)
  );

  // Called at a falling edge; the byte is sampled on the next rising edge.
  // Consecutive calls produce back-to-back bytes.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic issue_write(input logic [15:0] addr, input logic [15:0] data);
    model_mem[addr[7:0]] = data;
    exp_q.push_back(8'hA5);
    send_byte(CMD_WRITE);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    send_byte(data[15:8]);
    send_byte(data[7:0]);
  endtask

  task automatic issue_read(input logic [15:0] addr);
    logic [15:0] w;
    w = model_mem[addr[7:0]];
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    send_byte(CMD_READ);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: outputs checked");
  endtask

  task automatic test_write_read();
    tx_ready = 1'b1;
    issue_write(16'h0010, 16'h1234);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL wr_early_valid: got %b expected 0", tx_valid); end
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL wr_ack: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL wr_idle: got v=%b busy=%b expected 0 0", tx_valid, busy); end
    $display("write 0010=1234: ack checked");

    issue_read(16'h0010);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rd_early_valid: got %b expected 0", tx_valid); end
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL rd_hi: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL rd_lo: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rd_idle: got v=%b busy=%b expected 0 0", tx_valid, busy); end
    $display("read 0010: two bytes checked");
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b1;
    issue_write(16'h0011, 16'hCAFE);
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL b2b_ack: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got v=%b busy=%b expected 0 0", tx_valid, busy); end
    // Command byte lands in the very cycle after the ACK handshake.
    issue_read(16'h0011);
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL b2b_hi: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL b2b_lo: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    $display("back-to-back write/read 0011: checked");
  endtask

  task automatic test_backpressure();
    tx_ready = 1'b1;
    issue_write(16'h0030, 16'hBEEF);
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL bp_ack: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    tx_ready = 1'b0;
    issue_read(16'h0030);
    @(negedge clk);
    exp = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL bp_hold%0d: got v=%b %h expected v=1 %h", i, tx_valid, tx_byte, exp); end
      if (i < 2) @(negedge clk);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL bp_lo: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL bp_done: got %b expected 0", tx_valid); end
    $display("back-pressure read 0030: checked");
  endtask

  task automatic test_bad_cmd();
    tx_ready = 1'b1;
    send_byte(8'h7F);
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL badcmd_err: got err=%b busy=%b expected 1 0", err, busy); end
    @(negedge clk);
    total++; if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL badcmd_pulse: got err=%b busy=%b expected 0 0", err, busy); end
    issue_read(16'h0010);
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL badcmd_hi: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL badcmd_lo: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    $display("bad command 7F then read 0010: checked");
  endtask

  task automatic test_addr_wrap();
    tx_ready = 1'b1;
    issue_write(16'h0105, 16'h5A5A);
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL wrap_ack: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    issue_read(16'h0005);
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL wrap_hi: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL wrap_lo: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    $display("address wrap 0105 -> 0005: checked");
  endtask

  task automatic test_protocol_violation();
    tx_ready = 1'b0;
    issue_read(16'h0010);
    @(negedge clk);
    exp = exp_q[0];
    rx_byte  = CMD_READ;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL pv_err: got %b expected 1", err); end
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp || busy !== 1'b1) begin bad++; $display("FAIL pv_hold: got v=%b %h busy=%b expected v=1 %h busy=1", tx_valid, tx_byte, busy, exp); end
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL pv_pulse: got %b expected 0", err); end
    tx_ready = 1'b1;
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL pv_hi: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL pv_lo: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL pv_idle: got v=%b busy=%b expected 0 0", tx_valid, busy); end
    $display("protocol violation in TX_HI: checked");
  endtask

  task automatic test_reset_mid_frame();
    tx_ready = 1'b1;
    issue_write(16'h0020, 16'h1357);
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL rmf_ack: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    // Partial write frame; the model is not updated because it never commits.
    send_byte(CMD_WRITE);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'hAB);
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || tx_byte !== 8'h00) begin bad++; $display("FAIL rmf_reset: got v=%b busy=%b err=%b %h expected 0 0 0 00", tx_valid, busy, err, tx_byte); end
    rst_n = 1'b1;
    @(negedge clk);
    issue_read(16'h0020);
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL rmf_hi: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_byte !== exp) begin bad++; $display("FAIL rmf_lo: got v=%b %h expected v=1 %h", tx_valid, tx_byte, exp); end
    @(negedge clk);
    $display("reset mid-frame, read 0020: checked");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_bad_cmd();
    test_addr_wrap();
    test_protocol_violation();
    test_reset_mid_frame();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_empty: got %0d entries left expected 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_mem_responder.md
# serial_mem_responder

Byte-serial memory responder that sits on the far side of the CPU core's 8-bit serial bus, standing in for the external host/Arduino. It receives command frames (command, address, optional data) one byte at a time, performs 16-bit word reads and writes on an internal RAM, and returns response bytes through a valid/ready handshake. It is used as the memory model in core-level simulation and as the synthesizable memory endpoint on the FPGA build.

## Interface
- ADDR_W, 8, word-address width of internal RAM; depth = 2**ADDR_W 16-bit words.
- ACK_BYTE, 8'hA5, byte returned on completion of a write.

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_byte  in  8  byte from the CPU (the CPU's out_bus).
- rx_valid  in  1  one-cycle strobe; rx_byte is valid this cycle.
- tx_byte  out  8  response byte to the CPU (the CPU's in_bus).
- tx_valid  out  1  tx_byte is valid; held until accepted.
- tx_ready  in  1  CPU accepts tx_byte when tx_valid && tx_ready.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on a protocol error.

## Operation
- Frame: byte0 = command, byte1 = addr[15:8], byte2 = addr[7:0]; write frames add byte3 = data[15:8], byte4 = data[7:0].
- Commands: CMD_READ = 8'h01, CMD_WRITE = 8'h02. Any other command byte: err pulse, byte dropped, stay in IDLE.
- Address: 16 bits captured; RAM index = addr[ADDR_W-1:0]. Upper bits are ignored (wrap-around, not an error).
- States: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, RD_FETCH, WR_COMMIT, TX_HI, TX_LO, TX_ACK.
- IDLE -rx valid cmd-> ADDR_HI -rx-> ADDR_LO -rx-> RD_FETCH (read) or DATA_HI (write).
- DATA_HI -rx-> DATA_LO -rx-> WR_COMMIT -> TX_ACK -accepted-> IDLE.
- RD_FETCH -> TX_HI (tx_byte = word[15:8]) -accepted-> TX_LO (tx_byte = word[7:0]) -accepted-> IDLE.
- Receive states advance only on rx_valid. Response states advance only on tx_valid && tx_ready.
- rx_valid during RD_FETCH, WR_COMMIT, or any TX_* state: byte ignored, err pulses, state unchanged.
- RAM contents are not reset. Reset aborts any frame: no partial write is committed unless WR_COMMIT has already completed.

## Timing
- Reset values: tx_byte = 8'h00, tx_valid = 0, busy = 0, err = 0, state = IDLE. Captured address and data registers are 0.
- Read latency: last address byte accepted in cycle t; RD_FETCH in t+1 (synchronous RAM read); tx_valid high with the high byte in t+2.
- Write latency: low data byte accepted in cycle t; RAM written at the end of t+1 (WR_COMMIT); tx_valid high with ACK_BYTE in t+2.
- A read issued in the cycle immediately after a write's ACK is accepted returns the new data (no read-after-write hazard).
- tx_byte is stable and tx_valid stays high while tx_ready is low. Back-pressure is unlimited; there is no timeout.
- tx_valid deasserts in the cycle after the final accepting handshake. A new command byte is accepted in that cycle, because the state is already IDLE.
- tx_valid and tx_ready may both be high on the first cycle of TX_HI: zero-wait acceptance.
- err is registered and high for exactly one cycle, in the cycle after the offending rx_valid.

## Structure
- Package serial_mem_pkg holds:
  - CMD_READ and CMD_WRITE constants;
  - the default ACK_BYTE;
  - typedef enum logic [3:0] smr_state_t covering the ten states.
- Sub-module word_ram (parameter ADDR_W; 16-bit synchronous single-port RAM, registered read, write enable) holds the storage.
- The FSM, the address and data capture registers, and the tx output register live in serial_mem_responder.

## Test plan
- Write then read: send 02,00,10,12,34 with tx_ready=1 -> ACK 0xA5 two cycles after the last byte. Then send 01,00,10 -> tx bytes 0x12, 0x34 on consecutive cycles.
- Back-pressure: read of a word holding 0xBEEF with tx_ready held low for 3 cycles -> tx_byte stays 0xBE and tx_valid stays high for all 3 cycles. Then 0xBE and 0xEF each transfer on one handshake.
- Bad command: send 7F -> err pulses once, busy stays 0. A following 01,00,10 read completes normally.
- Address wrap (ADDR_W=8): write 0x5A5A to 0x0105, then read 0x0005 -> 0x5A, 0x5A.
- Protocol violation: rx_valid with byte 0x01 while in TX_HI -> err pulses. State, tx_byte and the read data are unchanged.
- Reset mid-frame: rst_n low after 02,00,20,AB -> tx_valid=0, busy=0, state IDLE. A subsequent read of 0x0020 returns the old contents, not 0xAB--.
